// File: rtl/hft_order_gate.sv
// hft_order_gate
//   Order gateway and pre-trade risk stage. Captures each completed trading
//   decision, checks it against quantity, position-exposure and message-rate
//   limits, and presents accepted orders on a valid/ready port. Exchange fills
//   update the signed position, which is fed back to the decision engine.
//
// Ports
//   ap_clk, ap_rst         clock; synchronous active-high reset
//   dec_valid/action/price/qty
//                          one-cycle decision strobe (action 00 hold, 01 buy,
//                          10 sell, 11 reserved) with limit price and quantity
//   ord_valid/ready        order handshake
//   ord_side/price/qty/id  order fields, stable while ord_valid is high
//   fill_valid/side/price/qty
//                          exchange fill strobe, accepted in any cycle
//   current_position       signed two's-complement position
//   last_fill_price/side   most recent fill
//   open_buy_qty/open_sell_qty
//                          quantity sent but not yet filled, per side
//   rej_count, drop_count  saturating risk-rejection / busy-drop counters
module hft_order_gate #(
    parameter int MAX_POS       = 1000,
    parameter int MAX_QTY       = 500,
    parameter int TOKEN_MAX     = 8,
    parameter int REFILL_CYCLES = 1000
) (
    input  logic        ap_clk,
    input  logic        ap_rst,
    input  logic        dec_valid,
    input  logic [1:0]  dec_action,
    input  logic [31:0] dec_price,
    input  logic [31:0] dec_qty,
    output logic        ord_valid,
    input  logic        ord_ready,
    output logic        ord_side,
    output logic [31:0] ord_price,
    output logic [31:0] ord_qty,
    output logic [15:0] ord_id,
    input  logic        fill_valid,
    input  logic        fill_side,
    input  logic [31:0] fill_price,
    input  logic [31:0] fill_qty,
    output logic [31:0] current_position,
    output logic [31:0] last_fill_price,
    output logic        last_fill_side,
    output logic [31:0] open_buy_qty,
    output logic [31:0] open_sell_qty,
    output logic [15:0] rej_count,
    output logic [15:0] drop_count
);

    localparam int TOK_W = $clog2(TOKEN_MAX + 1);
    localparam int REF_W = $clog2(REFILL_CYCLES);

    localparam logic signed [33:0] POS_LIMIT = 34'(MAX_POS);
    localparam logic signed [33:0] NEG_LIMIT = -34'(MAX_POS);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CHECK = 2'd1,
        ISSUE = 2'd2
    } state_t;

    state_t             state;
    state_t             state_next;
    logic               capture;
    logic               reject;
    logic               handshake;
    logic               drop;
    logic               risk_ok;
    logic [TOK_W-1:0]   tokens;
    logic [TOK_W-1:0]   tokens_next;
    logic [REF_W-1:0]   refill_cnt;
    logic               refill;
    logic [31:0]        buy_fill_dec;
    logic [31:0]        sell_fill_dec;
    logic [31:0]        open_buy_next;
    logic [31:0]        open_sell_next;
    logic [31:0]        position_next;
    logic signed [33:0] buy_sum;
    logic signed [33:0] sell_sum;

    // Order port is a pure decode of the state register.
    assign ord_valid = (state == ISSUE);

    // Risk sums widened to 34 bits so position +/- two 32-bit unsigned terms
    // cannot wrap into a false pass.
    assign buy_sum  = $signed({{2{current_position[31]}}, current_position})
                    + $signed({2'b00, open_buy_qty}) + $signed({2'b00, ord_qty});
    assign sell_sum = $signed({{2{current_position[31]}}, current_position})
                    - $signed({2'b00, open_sell_qty}) - $signed({2'b00, ord_qty});

    assign risk_ok = (ord_qty != 32'd0) && (ord_qty <= 32'(MAX_QTY)) && (tokens != '0)
                   && (ord_side ? (sell_sum >= NEG_LIMIT) : (buy_sum <= POS_LIMIT));

    // A busy FSM discards any non-hold decision.
    assign drop = dec_valid && (dec_action != 2'b00) && (state != IDLE);

    // NOTE: non-blocking assignments in clocked blocks so every flop samples
    // the values from before the edge, regardless of statement order.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) state <= IDLE;
        else        state <= state_next;
    end

    // NOTE: every output of this block gets a default first, so no path can
    // leave one unassigned and infer a latch.
    always_comb begin
        state_next = state;
        capture    = 1'b0;
        reject     = 1'b0;
        handshake  = 1'b0;
        case (state)
            IDLE: begin
                if (dec_valid) begin
                    if (dec_action == 2'b01 || dec_action == 2'b10) begin
                        capture    = 1'b1;
                        state_next = CHECK;
                    end else if (dec_action == 2'b11) begin
                        reject = 1'b1;
                    end
                end
            end
            CHECK: begin
                if (risk_ok) begin
                    state_next = ISSUE;
                end else begin
                    reject     = 1'b1;
                    state_next = IDLE;
                end
            end
            ISSUE: begin
                if (ord_ready) begin
                    handshake  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Token bucket and fill/handshake bookkeeping.
    always_comb begin
        int tok_sum;
        refill  = (refill_cnt == REF_W'(REFILL_CYCLES - 1));
        tok_sum = int'(tokens) - int'(handshake) + int'(refill);
        tokens_next = (tok_sum > TOKEN_MAX) ? TOK_W'(TOKEN_MAX) : TOK_W'(tok_sum);

        // Fills retire at most what is open on their side, clamping at zero.
        buy_fill_dec  = 32'd0;
        sell_fill_dec = 32'd0;
        position_next = current_position;
        if (fill_valid) begin
            if (fill_side) begin
                sell_fill_dec = (fill_qty < open_sell_qty) ? fill_qty : open_sell_qty;
                position_next = current_position - fill_qty;
            end else begin
                buy_fill_dec  = (fill_qty < open_buy_qty) ? fill_qty : open_buy_qty;
                position_next = current_position + fill_qty;
            end
        end
        open_buy_next  = open_buy_qty  - buy_fill_dec
                       + ((handshake && !ord_side) ? ord_qty : 32'd0);
        open_sell_next = open_sell_qty - sell_fill_dec
                       + ((handshake && ord_side) ? ord_qty : 32'd0);
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            ord_side         <= 1'b0;
            ord_price        <= 32'd0;
            ord_qty          <= 32'd0;
            ord_id           <= 16'd0;
            current_position <= 32'd0;
            open_buy_qty     <= 32'd0;
            open_sell_qty    <= 32'd0;
            last_fill_price  <= 32'd0;
            last_fill_side   <= 1'b0;
            rej_count        <= 16'd0;
            drop_count       <= 16'd0;
            tokens           <= TOK_W'(TOKEN_MAX);
            refill_cnt       <= '0;
        end else begin
            // ord_* double as the latched decision; they only change in IDLE.
            if (capture) begin
                ord_side  <= dec_action[1];
                ord_price <= dec_price;
                ord_qty   <= dec_qty;
            end
            if (handshake)                      ord_id     <= ord_id + 16'd1;
            if (reject && rej_count != 16'hFFFF) rej_count  <= rej_count + 16'd1;
            if (drop && drop_count != 16'hFFFF)  drop_count <= drop_count + 16'd1;
            if (fill_valid) begin
                last_fill_price <= fill_price;
                last_fill_side  <= fill_side;
            end
            current_position <= position_next;
            open_buy_qty     <= open_buy_next;
            open_sell_qty    <= open_sell_next;
            tokens           <= tokens_next;
            refill_cnt       <= refill ? '0 : refill_cnt + REF_W'(1);
        end
    end

endmodule

// File: doc/hft_order_gate.md
# hft_order_gate

Order gateway and pre-trade risk stage directly downstream of `hft_zero_plus`. It captures each completed trading decision (`action`/`price`/`quantity` qualified by `ap_done`) and checks it against quantity, position-exposure and message-rate limits. Accepted orders are presented on a valid/ready order port. Exchange fills update the signed position, which is fed back to `hft_zero_plus` as `current_position`/`last_fill_price`/`last_fill_side`.

## Interface
Parameters:
- MAX_POS, 1000: absolute position-exposure limit (shares).
- MAX_QTY, 500: largest single-order quantity.
- TOKEN_MAX, 8: rate-limiter bucket depth (orders).
- REFILL_CYCLES, 1000: cycles per token refill; must be ≥2.

Ports:
- ap_clk  in  1  sole clock.
- ap_rst  in  1  synchronous, active-high reset.
- dec_valid  in  1  one-cycle decision strobe; driven by `hft_zero_plus` `ap_done`.
- dec_action  in  2  00 hold, 01 buy, 10 sell, 11 reserved.
- dec_price  in  32  limit price in cents.
- dec_qty  in  32  unsigned quantity.
- ord_valid  out  1  order available.
- ord_ready  in  1  downstream accepts the order.
- ord_side  out  1  0 buy, 1 sell.
- ord_price  out  32  order price.
- ord_qty  out  32  order quantity.
- ord_id  out  16  sequence number, wraps 0xFFFF→0.
- fill_valid  in  1  fill strobe, allowed in any cycle.
- fill_side  in  1  0 buy, 1 sell.
- fill_price  in  32  fill price.
- fill_qty  in  32  fill quantity.
- current_position  out  32  signed two's-complement position.
- last_fill_price  out  32  price of the most recent fill.
- last_fill_side  out  1  side of the most recent fill.
- open_buy_qty  out  32  buy quantity sent but not yet filled.
- open_sell_qty  out  32  sell quantity sent but not yet filled.
- rej_count  out  16  risk rejections; saturates at 0xFFFF.
- drop_count  out  16  decisions arriving while busy; saturates at 0xFFFF.

## Operation
- FSM states: IDLE, CHECK, ISSUE.
- IDLE:
  - On dec_valid with action 01/10, latch side/price/qty and go to CHECK.
  - Action 00 is ignored and not counted.
  - Action 11 increments rej_count and stays in IDLE.
- CHECK (one cycle). All of the following must pass, evaluated on registered values:
  - qty ≠ 0.
  - qty ≤ MAX_QTY.
  - tokens > 0.
  - Buy: position + open_buy_qty + qty ≤ MAX_POS.
  - Sell: position − open_sell_qty − qty ≥ −MAX_POS.
  - Compute limit sums in 34-bit signed arithmetic; no wrap.
  - On pass, go to ISSUE. On fail, increment rej_count and go to IDLE.
- ISSUE:
  - ord_valid is high. ord_side/price/qty/id hold stable until the handshake.
  - The handshake (ord_valid & ord_ready) ends the state. In that cycle: ord_id += 1, open_{side}_qty += qty, tokens −= 1, then go to IDLE.
- dec_valid in CHECK or ISSUE, with action ≠ 00: decision discarded, drop_count += 1.
- Fill, processed every cycle independently of the FSM:
  - Buy fill: position += qty. Sell fill: position −= qty.
  - The matching open qty is reduced by min(open, fill_qty) and clamps at 0.
  - last_fill_price and last_fill_side are updated.
- Fill and handshake in the same cycle: both updates apply to their own registers.
- Token bucket:
  - Refill counter counts 0..REFILL_CYCLES−1. On terminal count it adds one token.
  - Update rule: tokens_next = min(TOKEN_MAX, tokens − consume + refill). Simultaneous consume and refill at full leaves TOKEN_MAX.
- Reset (synchronous) values:
  - FSM → IDLE; ord_valid 0.
  - ord_side 0, ord_price 0, ord_qty 0, ord_id 0.
  - Position, open quantities, last_fill_price, last_fill_side, rej_count, drop_count all 0.
  - tokens = TOKEN_MAX; refill counter 0.
  - A reset asserted mid-ISSUE discards the pending order with no handshake.

## Timing
- dec_valid sampled at edge N → CHECK during N+1 → ord_valid high from N+2. Accept latency is 2 cycles.
- Rejection: rej_count is updated at edge N+2; ord_valid never rises.
- With ord_ready held high, ord_valid is high for exactly one cycle. The next decision is accepted the cycle after the handshake, giving a minimum decision period of 3 cycles.
- Fill at edge M → current_position/open/last_fill_* valid after edge M (registered, 1-cycle latency). A fill in cycle N+1 is not seen by that CHECK.
- All outputs are registered; no combinational input→output paths.

## Test plan
- Buy accept: dec buy 100 @ 80300, ord_ready=1 → ord_valid 2 cycles later with side 0, price 80300, qty 100, id 0; open_buy_qty=100. Then fill buy 100 @ 80300 → current_position=100, open_buy_qty=0, last_fill_price=80300.
- Position limit: fill buy 950, then dec buy 100 → no ord_valid, rej_count=1. Then dec sell 100 → accepted, ord_side=1.
- Quantity bounds: qty 0 and qty 501 (MAX_QTY=500) each → rejected, rej_count=2. qty 500 → accepted.
- Rate limit: REFILL_CYCLES=1000, nine back-to-back buys of qty 1 with fills → 8 orders (ids 0–7), ninth rejected. After 1000 cycles, one buy is accepted with id 8.
- Backpressure and drop: ord_ready=0 for 20 cycles → ord_* fields stable. dec_valid sell 10 mid-stall → drop_count=1. ord_ready=1 → exactly one handshake, state returns to IDLE.
- Reset mid-ISSUE: ap_rst for 1 cycle while ord_valid=1 → ord_valid=0, ord_id=0, tokens=TOKEN_MAX, all counters 0 on the next cycle.
